// File: rtl/sar_cmp_search.sv
// sar_cmp_search
//   Successive-approximation search engine driving a comparator's A operand.
//   A three-way binary search over 0 .. 2^W-1 locates the static B operand
//   from the comparator's l/e/g flags.
//
// Ports:
//   clk     rising-edge clock
//   rst     synchronous active-high reset (aborts a search, no done pulse)
//   start   request a new search (sampled only in IDLE)
//   cmp_l   comparator flag: trial <  target
//   cmp_e   comparator flag: trial == target
//   cmp_g   comparator flag: trial >  target
//   trial   registered operand driven to the comparator A input
//   busy    high while a search is in progress (DRIVE/EVAL)
//   done    one-cycle pulse at the end of a search (FIN)
//   found   result is valid (comparator reported equal)
//   err     illegal flag combination or bound violation ended the search
//   result  located target value, 0 when found=0
//   probes  number of EVAL cycles used by the last search
module sar_cmp_search #(
  parameter int W  = 4,
  parameter int PW = $clog2(W + 2)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic          cmp_l,
  input  logic          cmp_e,
  input  logic          cmp_g,
  output logic [W-1:0]  trial,
  output logic          busy,
  output logic          done,
  output logic          found,
  output logic          err,
  output logic [W-1:0]  result,
  output logic [PW-1:0] probes
);

  typedef enum logic [1:0] {IDLE, DRIVE, EVAL, FIN} state_t;

  localparam logic [W-1:0] ALL_ONES = '1;

  state_t         state, state_nxt;
  logic [W-1:0]   lo, hi;
  logic [W-1:0]   lo_nxt, hi_nxt, mid;
  logic [W:0]     sum;
  logic           ev_found, ev_err;

  // Flag decode for the EVAL cycle. Bound guards stop lo/hi from crossing,
  // so trial-1 / trial+1 can never wrap.
  always_comb begin
    lo_nxt   = lo;
    hi_nxt   = hi;
    ev_found = 1'b0;
    ev_err   = 1'b0;
    case ({cmp_l, cmp_e, cmp_g})
      3'b010: ev_found = 1'b1;
      3'b001: begin
        if (trial == lo) ev_err = 1'b1;
        else             hi_nxt = trial - 1'b1;
      end
      3'b100: begin
        if (trial == hi) ev_err = 1'b1;
        else             lo_nxt = trial + 1'b1;
      end
      default: ev_err = 1'b1;
    endcase
    // W+1-bit sum so lo+hi cannot overflow before the halving.
    sum = {1'b0, lo_nxt} + {1'b0, hi_nxt};
    mid = W'(sum >> 1);
  end

  // State register
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = DRIVE;
      DRIVE:   state_nxt = EVAL;
      EVAL:    state_nxt = (ev_found || ev_err) ? FIN : DRIVE;
      FIN:     state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Output decode
  always_comb begin
    busy = (state == DRIVE) || (state == EVAL);
    done = (state == FIN);
  end

  // Search datapath and held result registers
  always_ff @(posedge clk) begin
    if (rst) begin
      trial  <= '0;
      lo     <= '0;
      hi     <= '0;
      result <= '0;
      probes <= '0;
      found  <= 1'b0;
      err    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            lo     <= '0;
            hi     <= ALL_ONES;
            trial  <= ALL_ONES >> 1;
            result <= '0;
            probes <= '0;
            found  <= 1'b0;
            err    <= 1'b0;
          end
        end
        EVAL: begin
          probes <= probes + 1'b1;
          if (ev_found) begin
            found  <= 1'b1;
            result <= trial;
          end else if (ev_err) begin
            err    <= 1'b1;
            found  <= 1'b0;
          end else begin
            lo     <= lo_nxt;
            hi     <= hi_nxt;
            trial  <= mid;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_sar_cmp_search.sv
module tb_sar_cmp_search;

  localparam int W  = 4;
  localparam int PW = $clog2(W + 2);

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic          cmp_l, cmp_e, cmp_g;
  logic [W-1:0]  trial;
  logic          busy, done, found, err;
  logic [W-1:0]  result;
  logic [PW-1:0] probes;

  sar_cmp_search #(.W(W), .PW(PW)) dut (
    .clk    (clk),
    .rst    (rst),
    .start  (start),
    .cmp_l  (cmp_l),
    .cmp_e  (cmp_e),
    .cmp_g  (cmp_g),
    .trial  (trial),
    .busy   (busy),
    .done   (done),
    .found  (found),
    .err    (err),
    .result (result),
    .probes (probes)
  );

  always #5 clk = ~clk;

  // Comparator model: 0 = honest, 1 = l&g, 2 = no flags, 3 = always g
  logic [W-1:0] tgt;
  int           mode;

  always_comb begin
    cmp_l = 1'b0;
    cmp_e = 1'b0;
    cmp_g = 1'b0;
    case (mode)
      0: begin
        cmp_l = (trial <  tgt);
        cmp_e = (trial == tgt);
        cmp_g = (trial >  tgt);
      end
      1: begin
        cmp_l = 1'b1;
        cmp_g = 1'b1;
      end
      3: cmp_g = 1'b1;
      default: ;
    endcase
  end

  typedef struct {
    bit   f;
    bit   e;
    int   res;
    int   p;
    int   start_cyc;
  } exp_t;

  exp_t eq[$];
  int   tq[$];
  int   asserts = 0;
  int   fails   = 0;
  int   cyc     = 0;
  int   bcnt    = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input int act, input int exp);
    asserts++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor: trial checked at each DRIVE cycle (odd busy cycles), results at done.
  always @(negedge clk) begin
    if (rst) begin
      bcnt = 0;
    end else begin
      if (busy) begin
        bcnt++;
        if (bcnt % 2 == 1) begin
          if (tq.size() == 0) begin
            asserts++;
            fails++;
            $display("FAIL trial_unexpected: got %0d, expected no further probe", trial);
          end else begin
            chk("trial", int'(trial), tq.pop_front());
          end
        end
      end else begin
        bcnt = 0;
      end
      if (done) begin
        if (eq.size() == 0) begin
          asserts++;
          fails++;
          $display("FAIL done_unexpected: got done=1, expected none pending");
        end else begin
          exp_t x;
          x = eq.pop_front();
          chk("found",   int'(found),  int'(x.f));
          chk("err",     int'(err),    int'(x.e));
          chk("result",  int'(result), x.res);
          chk("probes",  int'(probes), x.p);
          chk("busy_in_fin", int'(busy), 0);
          // cycle 1 is the cycle following the start-sampling edge
          chk("done_cycle", cyc - x.start_cyc + 1, 2 * x.p + 1);
        end
      end
    end
  end

  task automatic push_exp(input int p, input bit f, input bit e, input int res);
    exp_t x;
    x.f = f; x.e = e; x.res = res; x.p = p; x.start_cyc = cyc;
    eq.push_back(x);
  endtask

  task automatic issue(input int t, input int md, input int p, input bit f,
                       input bit e, input int res);
    @(negedge clk);
    tgt   = W'(t);
    mode  = md;
    start = 1'b1;
    @(posedge clk);
    #1;
    push_exp(p, f, e, res);
    start = 1'b0;
  endtask

  task automatic wait_done();
    bit seen = 1'b0;
    int t = 0;
    while (!seen && t < 60) begin
      @(negedge clk);
      #1;
      if (done) seen = 1'b1;
      t++;
    end
    if (!seen) begin
      asserts++;
      fails++;
      $display("FAIL done_timeout: got no done within %0d cycles, expected done", t);
    end
  endtask

  task automatic trials(input int a, input int b, input int c, input int d, input int e2);
    int v[5];
    v = '{a, b, c, d, e2};
    foreach (v[i]) if (v[i] >= 0) tq.push_back(v[i]);
  endtask

  initial begin
    rst   = 1'b1;
    start = 1'b0;
    tgt   = '0;
    mode  = 0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_trial",  int'(trial),  0);
    chk("rst_busy",   int'(busy),   0);
    chk("rst_done",   int'(done),   0);
    chk("rst_found",  int'(found),  0);
    chk("rst_err",    int'(err),    0);
    chk("rst_result", int'(result), 0);
    chk("rst_probes", int'(probes), 0);
    @(negedge clk);
    rst = 1'b0;

    // Hit on the first probe
    trials(7, -1, -1, -1, -1);
    issue(7, 0, 1, 1, 0, 7);
    wait_done();

    // Top of range
    trials(7, 11, 13, 14, 15);
    issue(15, 0, 5, 1, 0, 15);
    wait_done();

    // l and g together on the first EVAL; result must clear from 15
    trials(7, -1, -1, -1, -1);
    issue(9, 1, 1, 0, 1, 0);
    wait_done();

    // Bottom of range, hi must not wrap
    trials(7, 3, 1, 0, -1);
    issue(0, 0, 4, 1, 0, 0);
    wait_done();

    // No flags at all
    trials(7, -1, -1, -1, -1);
    issue(5, 2, 1, 0, 1, 0);
    wait_done();

    // Mixed directions
    trials(7, 11, 9, 10, -1);
    issue(10, 0, 4, 1, 0, 10);
    wait_done();

    // Comparator stuck at g: bound guard fires at trial==lo==0
    trials(7, 3, 1, 0, -1);
    issue(12, 3, 4, 0, 1, 0);
    wait_done();

    // start pulsed while busy is ignored
    trials(7, 11, 9, 8, -1);
    issue(8, 0, 4, 1, 0, 8);
    repeat (2) @(posedge clk);
    #1 start = 1'b1;
    repeat (2) @(posedge clk);
    #1 start = 1'b0;
    wait_done();

    // Back-to-back: start raised during FIN is only accepted in the following IDLE
    trials(7, 11, 9, 10, -1);
    issue(10, 0, 4, 1, 0, 10);
    wait_done();
    tgt   = W'(15);
    mode  = 0;
    start = 1'b1;
    trials(7, 11, 13, 14, 15);
    @(posedge clk);
    @(posedge clk);
    #1;
    push_exp(5, 1, 0, 15);
    start = 1'b0;
    chk("b2b_found",  int'(found),  0);
    chk("b2b_err",    int'(err),    0);
    chk("b2b_result", int'(result), 0);
    chk("b2b_probes", int'(probes), 0);
    chk("b2b_busy",   int'(busy),   1);
    wait_done();

    // Reset during the third probe's EVAL aborts without done
    trials(7, 11, 13, -1, -1);
    issue(15, 0, 0, 0, 0, 0);
    void'(eq.pop_back());
    repeat (5) @(posedge clk);
    #1;
    chk("abort_busy_before", int'(busy), 1);
    rst = 1'b1;
    @(posedge clk);
    #1;
    chk("abort_busy",  int'(busy),  0);
    chk("abort_trial", int'(trial), 0);
    chk("abort_done",  int'(done),  0);
    @(negedge clk);
    rst = 1'b0;
    repeat (4) @(posedge clk);

    // Recovery after reset
    trials(7, 11, 13, 12, -1);
    issue(12, 0, 4, 1, 0, 12);
    wait_done();
    repeat (3) @(posedge clk);
    #1;
    chk("pending_results", eq.size(), 0);
    chk("pending_trials",  tq.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", asserts, fails);
    $finish;
  end

endmodule
